// File: rtl/uart_tx_drain.sv
// Read side of the JTAG UART byte queue. It drains pending bytes through the registered read port and sends them as 8N1 serial.
// Defining UART_TX_PARITY_EN adds an even-parity bit, which makes each frame 8E1.
module uart_tx_drain #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] waddr_i,
    output logic [ADDR_W-1:0] raddr_o,
    input  logic [7:0]        rdata_i,
    output logic              tx_o,
    output logic              busy_o,
    output logic              empty_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn;
    logic [7:0]    shift;
`ifdef UART_TX_PARITY_EN
    logic          par;
`endif

    assign empty_o = (raddr_o == waddr_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            raddr_o <= '0;
            tx_o    <= 1'b1;
            busy_o  <= 1'b0;
            cnt     <= '0;
            bitn    <= '0;
            shift   <= '0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx_o <= 1'b1;
                    if (!empty_o) begin
                        state  <= FETCH;
                        busy_o <= 1'b1;
                    end
                end
                // rdata_i now reflects the slot under raddr_o, which was sampled one edge ago
                FETCH: begin
                    shift   <= rdata_i;
`ifdef UART_TX_PARITY_EN
                    par     <= ^rdata_i;
`endif
                    raddr_o <= raddr_o + ADDR_W'(1);
                    tx_o    <= 1'b0;
                    cnt     <= '0;
                    state   <= START;
                end
                START: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        bitn  <= '0;
                        tx_o  <= shift[0];
                        state <= DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (bitn == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_o  <= par;
                            state <= PARITY;
`else
                            tx_o  <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            shift <= shift >> 1;
                            tx_o  <= shift[1];
                            bitn  <= bitn + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        tx_o  <= 1'b1;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt == LAST) begin
                        cnt    <= '0;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_drain.sv
// Self-checking bench for uart_tx_drain. It includes a queue storage model, and each frame schedule is derived from the byte timeline.
module tb_uart_tx_drain;
    localparam int CPB = 4;
    localparam int AW  = 3;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we = 1'b0;
    logic [7:0]    wdata = 8'h00;
    logic [AW-1:0] waddr, raddr;
    logic [7:0]    rdata;
    logic          tx, busy, empty;
    logic [7:0]    mem [8];

    int errors = 0;
    int checks = 0;

    int         n;
    logic [7:0] bytes [16];
    int         w_at [16];
    int         s_at [16];
    int         base_r, base_w;
    logic [5:0] trace [4096];
    logic [7:0] rx [16];
    int         nrx;

    always #5 clk = ~clk;

    uart_tx_drain #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .waddr_i(waddr), .raddr_o(raddr),
        .rdata_i(rdata), .tx_o(tx), .busy_o(busy), .empty_o(empty)
    );

    // Writer plus storage; the registered read returns the old data on a same-slot collision.
    always @(posedge clk) begin
        if (rst) waddr <= '0;
        else if (we) begin
            mem[waddr] <= wdata;
            waddr <= waddr + 3'd1;
        end
        rdata <= mem[raddr];
    end

    // A start bit begins 2 edges after its byte is written, or 2 edges after the previous frame ends.
    function automatic void plan();
        for (int i = 0; i < n; i++) begin
            int t;
            t = w_at[i];
            if (i > 0 && s_at[i-1] + FL > t) t = s_at[i-1] + FL;
            s_at[i] = t + 2;
        end
    endfunction

    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
        if (j == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Expected {tx, busy, raddr, empty} just after edge k of the scenario.
    function automatic logic [5:0] model(input int k);
        int nr = 0, nw = 0;
        logic t = 1'b1, b = 1'b0;
        logic [AW-1:0] r, w;
        for (int i = 0; i < n; i++) begin
            if (w_at[i] <= k) nw++;
            if (s_at[i] <= k) nr++;
            if (k >= s_at[i] && k < s_at[i] + FL) t = frame_bit(bytes[i], (k - s_at[i]) / CPB);
            if (k >= s_at[i] - 1 && k < s_at[i] + FL) b = 1'b1;
        end
        r = AW'(base_r + nr);
        w = AW'(base_w + nw);
        return {t, b, r, (r == w)};
    endfunction

    task automatic play(input int len);
        base_r = int'(raddr);
        base_w = int'(waddr);
        for (int k = 0; k < len; k++) begin
            we = 1'b0;
            for (int i = 0; i < n; i++)
                if (w_at[i] == k) begin
                    we = 1'b1;
                    wdata = bytes[i];
                end
            @(posedge clk); #1;
            we = 1'b0;
            trace[k] = {tx, busy, raddr, empty};
        end
    endtask

    // Plain UART receiver that works on the recorded tx trace.
    function automatic void decode(input int len);
        int k = 1;
        nrx = 0;
        while (k + FL < len) begin
            if (trace[k][5] == 1'b0 && trace[k-1][5] == 1'b1) begin
                logic [7:0] d;
                for (int j = 0; j < 8; j++) d[j] = trace[k + CPB*(j+1) + CPB/2][5];
                if (nrx < 16) rx[nrx] = d;
                nrx++;
                k += FL - 1;
            end else k++;
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
        checks++; if (raddr !== 3'd0) begin errors++; $display("FAIL reset_raddr got %0d want 0", raddr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({tx, busy, raddr, empty} !== 6'b100001) begin
                errors++; $display("FAIL reset_idle_hold got %b want 100001", {tx, busy, raddr, empty});
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int len;
        n = 1; bytes[0] = 8'h55; w_at[0] = 0;
        plan(); len = s_at[0] + FL + 4;
        play(len);
        for (int k = 0; k < len; k++) begin
            checks++;
            if (trace[k] !== model(k)) begin
                errors++; $display("FAIL single cyc %0d got %b want %b", k, trace[k], model(k));
            end
        end
        checks++;
        if (trace[1][5] !== 1'b1 || trace[2][5] !== 1'b0) begin
            errors++; $display("FAIL single_latency got tx1=%b tx2=%b want 1,0", trace[1][5], trace[2][5]);
        end
        decode(len);
        checks++; if (nrx != 1 || rx[0] !== 8'h55) begin
            errors++; $display("FAIL single_decode got n=%0d b=%h want 1 55", nrx, rx[0]);
        end
    endtask

    task automatic test_back_to_back();
        int len, f [3], nf;
        n = 3; bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hFF;
        w_at[0] = 0; w_at[1] = 1; w_at[2] = 2;
        plan(); len = s_at[2] + FL + 4;
        play(len);
        for (int k = 0; k < len; k++) begin
            checks++;
            if (trace[k] !== model(k)) begin
                errors++; $display("FAIL b2b cyc %0d got %b want %b", k, trace[k], model(k));
            end
        end
        nf = 0;
        for (int k = 1; k < len; k++)
            if (trace[k][5] == 1'b0 && trace[k-1][5] == 1'b1 && nf < 3 && (nf == 0 || k > f[nf-1] + FL)) begin
                f[nf] = k; nf++;
            end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (nf != 3 || f[i] - f[i-1] != FL + 2) begin
                errors++; $display("FAIL b2b_gap frame %0d got spacing %0d want %0d", i, (nf == 3) ? f[i] - f[i-1] : -1, FL + 2);
            end
        end
        decode(len);
        checks++; if (nrx != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", nrx); end
        for (int i = 0; i < 3 && i < nrx; i++) begin
            checks++;
            if (rx[i] !== bytes[i]) begin errors++; $display("FAIL b2b_byte %0d got %h want %h", i, rx[i], bytes[i]); end
        end
        checks++; if (trace[s_at[2]][0] !== 1'b1) begin
            errors++; $display("FAIL b2b_empty got %b want 1", trace[s_at[2]][0]);
        end
    endtask

    task automatic test_wrap();
        int len, fill;
        fill = (6 - int'(raddr)) & 7;
        if (fill > 0) begin
            n = fill;
            for (int i = 0; i < n; i++) begin bytes[i] = 8'($urandom); w_at[i] = i; end
            plan(); len = s_at[n-1] + FL + 4;
            play(len);
            for (int k = 0; k < len; k++) begin
                checks++;
                if (trace[k] !== model(k)) begin
                    errors++; $display("FAIL prefill cyc %0d got %b want %b", k, trace[k], model(k));
                end
            end
        end
        n = 7;
        for (int i = 0; i < 7; i++) begin bytes[i] = 8'(i + 1); w_at[i] = i; end
        plan(); len = s_at[6] + FL + 4;
        play(len);
        for (int k = 0; k < len; k++) begin
            checks++;
            if (trace[k] !== model(k)) begin
                errors++; $display("FAIL wrap cyc %0d got %b want %b", k, trace[k], model(k));
            end
        end
        decode(len);
        checks++; if (nrx != 7) begin errors++; $display("FAIL wrap_count got %0d want 7", nrx); end
        for (int i = 0; i < 7 && i < nrx; i++) begin
            checks++;
            if (rx[i] !== bytes[i]) begin errors++; $display("FAIL wrap_byte %0d got %h want %h", i, rx[i], bytes[i]); end
        end
        checks++; if (raddr !== 3'd5 || waddr !== 3'd5) begin
            errors++; $display("FAIL wrap_end got raddr=%0d waddr=%0d want 5 5", raddr, waddr);
        end
    endtask

    task automatic test_random();
        int len, t;
        n = 5; t = 0;
        for (int i = 0; i < n; i++) begin
            bytes[i] = 8'($urandom);
            t += $urandom_range(0, 60);
            w_at[i] = t;
        end
        plan(); len = s_at[n-1] + FL + 4;
        play(len);
        for (int k = 0; k < len; k++) begin
            checks++;
            if (trace[k] !== model(k)) begin
                errors++; $display("FAIL random cyc %0d got %b want %b", k, trace[k], model(k));
            end
        end
        decode(len);
        checks++; if (nrx != n) begin errors++; $display("FAIL random_count got %0d want %0d", nrx, n); end
        for (int i = 0; i < n && i < nrx; i++) begin
            checks++;
            if (rx[i] !== bytes[i]) begin errors++; $display("FAIL random_byte %0d got %h want %h", i, rx[i], bytes[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        int len;
        n = 3; bytes[0] = 8'h81; bytes[1] = 8'h12; bytes[2] = 8'h34;
        w_at[0] = 0; w_at[1] = 1; w_at[2] = 2;
        plan(); len = s_at[0] + CPB * 4 + 2;
        play(len);
        for (int k = 0; k < len; k++) begin
            checks++;
            if (trace[k] !== model(k)) begin
                errors++; $display("FAIL midrst_pre cyc %0d got %b want %b", k, trace[k], model(k));
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({tx, busy, raddr, empty} !== 6'b100001) begin
            errors++; $display("FAIL midrst_after got %b want 100001", {tx, busy, raddr, empty});
        end
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL midrst_quiet cyc %0d got tx=%b busy=%b want 1 0", c, tx, busy);
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int len, f0, f1, e0;
        n = 2; bytes[0] = 8'h07; bytes[1] = 8'h03;
        w_at[0] = 0; w_at[1] = 60;
        plan(); len = s_at[1] + FL + 4;
        play(len);
        for (int k = 0; k < len; k++) begin
            checks++;
            if (trace[k] !== model(k)) begin
                errors++; $display("FAIL parity cyc %0d got %b want %b", k, trace[k], model(k));
            end
        end
        f0 = -1; f1 = -1; e0 = -1;
        for (int k = 1; k < len; k++) begin
            if (f0 < 0 && trace[k][5] == 1'b0) f0 = k;
            else if (f0 >= 0 && e0 < 0 && trace[k][4] == 1'b0) e0 = k;
            else if (e0 >= 0 && f1 < 0 && trace[k][5] == 1'b0) f1 = k;
        end
        checks++; if (f0 < 0 || e0 - f0 != 44) begin
            errors++; $display("FAIL parity_len got %0d want 44", e0 - f0);
        end
        checks++; if (f0 < 0 || trace[f0 + 9*CPB + CPB/2][5] !== 1'b1) begin
            errors++; $display("FAIL parity_07 got %b want 1", (f0 < 0) ? 1'bx : trace[f0 + 9*CPB + CPB/2][5]);
        end
        checks++; if (f1 < 0 || trace[f1 + 9*CPB + CPB/2][5] !== 1'b0) begin
            errors++; $display("FAIL parity_03 got %b want 0", (f1 < 0) ? 1'bx : trace[f1 + 9*CPB + CPB/2][5]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_random();
        test_reset_midframe();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_drain.md
Name: uart_tx_drain

Overview:
Read-side controller for the 8-entry byte queue storage in the JTAG UART example. It owns the queue read pointer and compares it against the writer's pointer to detect pending bytes. It fetches each byte through the storage's 1-cycle registered read port and serializes it as 8N1 UART on a single TX line. The writer side keeps full detection (full = waddr+1 == raddr).

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535
ADDR_W, 3, queue pointer width (depth = 2^ADDR_W)

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous reset, active-high
waddr_i  input  ADDR_W  writer pointer, the next slot to be written; registered in the writer's clk domain
raddr_o  output  ADDR_W  read pointer, driven to the storage raddr
rdata_i  input  8  storage registered read data, equal to mem[raddr] as sampled at the previous edge
tx_o  output  1  UART serial out, idle high
busy_o  output  1  high in any state other than IDLE
empty_o  output  1  combinational (raddr_o == waddr_i)

Behaviour:
- Reset values: raddr_o=0, tx_o=1, busy_o=0, bit and cycle counters 0, state IDLE.
- empty_o follows raddr_o and waddr_i combinationally. After reset it is 1, provided the writer also resets waddr to 0.
- States: IDLE, FETCH, START, DATA, STOP (plus PARITY with the optional feature).
- IDLE: tx_o=1. If !empty_o, go to FETCH on the next edge.
- FETCH: exactly 1 cycle.
  - At its exit edge, capture shift_reg <= rdata_i and raddr_o <= raddr_o+1 (mod 2^ADDR_W), then go to START.
  - Rationale: the storage has read-before-write behaviour. rdata_i is valid no earlier than the second edge after empty_o first drops, so FETCH must not be skipped.
- START: tx_o=0 for CLKS_PER_BIT cycles.
- DATA:
  - 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - bit counter runs 0..7; shift_reg shifts right at each bit boundary.
- STOP: tx_o=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Back-to-back bytes: the gap between the end of STOP and the next start bit is 2 cycles (IDLE 1 + FETCH 1), with tx_o high throughout.
- Timing from a write: latency from the edge where waddr_i advances to tx_o falling is 2 cycles.
- Cycle counter: counts 0..CLKS_PER_BIT-1 and clears on every state or bit change. Its width is $clog2(CLKS_PER_BIT).
- Wrap-around: raddr_o goes 7->0 with no special handling, and empty detection holds across the wrap.
- The reader never drains past waddr_i. waddr_i changing mid-frame does not affect the current frame.
- Reset mid-frame: the frame is abandoned with no completion. On the next edge tx_o=1 and raddr_o=0, and queued bytes are discarded.
- The storage enable is not driven by this block. The reader never writes.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx_o carries even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame length is 11 bits.
- Undefined: no PARITY state, 8N1, frame length 10 bits.

Test Plan:
All tests use CLKS_PER_BIT=4, ADDR_W=3, and the storage model attached.
1. Assert rst for 2 cycles -> tx_o=1, raddr_o=0, busy_o=0, empty_o=1. Repeat with the reset held during idle; outputs stay unchanged.
2. Write 0x55 to slot 0 (waddr 0->1) -> tx_o falls 2 cycles after the waddr edge. Pattern is 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles. raddr_o=1 from the start bit; busy_o drops at the end of the stop bit.
3. Write 0xA5, 0x3C, 0xFF in consecutive cycles -> three frames in order, with exactly 2 high cycles between stop end and the next start. The decoded bytes match, and empty_o=1 after the last FETCH.
4. Pre-position pointers at 6. Write 7 bytes 0x01..0x07 to slots 6,7,0..4 -> all 7 decoded in order. raddr_o passes 7->0 and ends at 5 == waddr_i.
5. Assert rst for 1 cycle during data bit 3 of 0x81 with 2 bytes still queued (writer also reset) -> tx_o=1 on the next cycle, raddr_o=0, no further start bits for 50 cycles.
6. With UART_TX_PARITY_EN defined, send 0x07 -> the parity bit is 1 and the frame is 44 cycles. Send 0x03 -> the parity bit is 0.
